// File: rtl/mac_pkg.sv
// Package: mac_pkg
// Shared types and constants for the MAC sequencer slice.
//   state_e  : sequencer FSM states
//   tag_t    : per-slot tag travelling alongside the multiplier pipeline
//   MULT_LAT : multiplier latency in enabled edges (x/y sampled -> z valid)
//   OPND_W   : operand width, PROD_W : product width
package mac_pkg;

    localparam int unsigned MULT_LAT = 2;
    localparam int unsigned OPND_W   = 4;
    localparam int unsigned PROD_W   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Module: mac_tag_pipe
// Tag shift register of parameterised depth. Advances every edge; synchronous
// active-low clear empties every stage.
// Ports:
//   clk_i                   clock, rising edge
//   clear_ni                synchronous active-low clear
//   in_valid_i, in_last_i   tag entering stage 0
//   out_valid_o, out_last_o tag leaving the final stage
module mac_tag_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk_i,
    input  logic clear_ni,
    input  logic in_valid_i,
    input  logic in_last_i,
    output logic out_valid_o,
    output logic out_last_o
);

    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0].valid = in_valid_i;
        pipe_d[0].last  = in_last_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid_o = pipe_q[DEPTH-1].valid;
    assign out_last_o  = pipe_q[DEPTH-1].last;

endmodule

// File: rtl/multiplier.sv
// Module: multiplier
// 4x4 unsigned multiplier, two enabled edges from x/y sampling to z valid.
// Stage 1 holds two 2-bit-slice partial products, stage 2 holds their sum.
// With enable low both stages freeze and z reads as zero.
// Ports:
//   clock   clock, rising edge
//   reset   synchronous active-low reset
//   enable  pipeline advance / output enable
//   x, y    4-bit operands
//   z       8-bit product
module multiplier (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] z
);

    logic [5:0] pp_lo_q, pp_lo_d;
    logic [5:0] pp_hi_q, pp_hi_d;
    logic [7:0] prod_q, prod_d;

    always_comb begin
        pp_lo_d = pp_lo_q;
        pp_hi_d = pp_hi_q;
        prod_d  = prod_q;
        if (enable) begin
            pp_lo_d = {2'b00, x} * {4'b0000, y[1:0]};
            pp_hi_d = {2'b00, x} * {4'b0000, y[3:2]};
            prod_d  = {2'b00, pp_lo_q} + {pp_hi_q, 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            prod_q  <= '0;
        end else begin
            pp_lo_q <= pp_lo_d;
            pp_hi_q <= pp_hi_d;
            prod_q  <= prod_d;
        end
    end

    assign z = enable ? prod_q : '0;

endmodule

// File: rtl/mac_sequencer.sv
// Module: mac_sequencer
// Feeds 4-bit operand pairs into an external pipelined multiplier and sums the
// products of one vector (ended by in_last or by reaching MAX_LEN elements).
// The dot product is offered on a valid/ready result port.
// Ports:
//   clock, reset               clock and synchronous active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_last payload
//   mult_x/mult_y/mult_en      registered drive to the multiplier
//   mult_z                     multiplier product
//   res_valid/res_ready        result handshake
//   res_sum/res_count/res_ovf  sum mod 2^ACC_W, element count, sticky wrap flag
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_LEN  = 255,
    parameter int unsigned MULT_LAT = mac_pkg::MULT_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic              in_last,
    output logic [OPND_W-1:0] mult_x,
    output logic [OPND_W-1:0] mult_y,
    output logic              mult_en,
    input  logic [PROD_W-1:0] mult_z,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf
);

    state_e state_q, state_d;

    logic [OPND_W-1:0] mult_x_q, mult_x_d;
    logic [OPND_W-1:0] mult_y_q, mult_y_d;
    logic              mult_en_q, mult_en_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    // Pairs issued into the current vector; drives MAX_LEN termination.
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;

    logic             accept;
    logic             last_eff;
    logic             tag_valid;
    logic             tag_last;
    logic [ACC_W:0]   sum_ext;

    assign accept   = in_valid && in_ready;
    assign last_eff = in_last || (in_cnt_q == CNT_W'(MAX_LEN - 1));

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun: begin
                if (accept) begin
                    state_d = last_eff ? StDrain : StRun;
                end
            end
            StDrain: begin
                if (tag_valid && tag_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = reset;
            StRun:   in_ready  = reset;
            StDrain: in_ready  = 1'b0;
            StDone:  res_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand register and accumulator next state
    always_comb begin
        mult_x_d  = '0;
        mult_y_d  = '0;
        if (accept) begin
            mult_x_d = in_a;
            mult_y_d = in_b;
        end
        // Enable is held from the first accepted pair until the last tag retires.
        mult_en_d = (state_d == StRun) || (state_d == StDrain);

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        in_cnt_d = in_cnt_q;
        sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(mult_z);

        if (accept) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (tag_valid) begin
            acc_d = sum_ext[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_ext[ACC_W];
        end
        if (state_q == StDone && res_ready) begin
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            in_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mult_x_q  <= '0;
            mult_y_q  <= '0;
            mult_en_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            in_cnt_q  <= '0;
        end else begin
            mult_x_q  <= mult_x_d;
            mult_y_q  <= mult_y_d;
            mult_en_q <= mult_en_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            in_cnt_q  <= in_cnt_d;
        end
    end

    // Stage 0 is loaded together with mult_x/mult_y; the final stage lines up
    // with a valid mult_z.
    mac_tag_pipe #(
        .DEPTH(MULT_LAT + 1)
    ) u_tag_pipe (
        .clk_i      (clock),
        .clear_ni   (reset),
        .in_valid_i (accept),
        .in_last_i  (accept && last_eff),
        .out_valid_o(tag_valid),
        .out_last_o (tag_last)
    );

    assign mult_x    = mult_x_q;
    assign mult_y    = mult_y_q;
    assign mult_en   = mult_en_q;
    assign res_sum   = acc_q;
    assign res_count = cnt_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with the real multiplier. Two instances:
// dut 0 uses ACC_W=16/MAX_LEN=255, dut 1 uses ACC_W=8/MAX_LEN=4.
module tb_mac_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic        in_valid  [2];
    logic        in_last   [2];
    logic        res_ready [2];
    logic [3:0]  in_a      [2];
    logic [3:0]  in_b      [2];
    logic        in_ready  [2];
    logic        res_valid [2];
    logic        res_ovf   [2];
    logic        mult_en   [2];
    logic [3:0]  mult_x    [2];
    logic [3:0]  mult_y    [2];
    logic [15:0] res_sum   [2];
    logic [7:0]  res_count [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned AW = (g == 0) ? 16 : 8;
        localparam int unsigned ML = (g == 0) ? 255 : 4;
        logic          iv, il, ir, rr, rv, ro, en;
        logic [3:0]    ia, ib, mx, my;
        logic [7:0]    mz, rc;
        logic [AW-1:0] rs;

        assign iv = in_valid[g];
        assign il = in_last[g];
        assign ia = in_a[g];
        assign ib = in_b[g];
        assign rr = res_ready[g];

        mac_sequencer #(
            .ACC_W(AW), .CNT_W(8), .MAX_LEN(ML), .MULT_LAT(2)
        ) u_dut (
            .clock(clock), .reset(rst_n),
            .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_last(il),
            .mult_x(mx), .mult_y(my), .mult_en(en), .mult_z(mz),
            .res_valid(rv), .res_ready(rr), .res_sum(rs), .res_count(rc), .res_ovf(ro)
        );

        multiplier u_mult (
            .clock(clock), .reset(rst_n), .enable(en), .x(mx), .y(my), .z(mz)
        );

        assign in_ready[g]  = ir;
        assign res_valid[g] = rv;
        assign res_ovf[g]   = ro;
        assign mult_en[g]   = en;
        assign mult_x[g]    = mx;
        assign mult_y[g]    = my;
        assign res_sum[g]   = 16'(rs);
        assign res_count[g] = rc;
    end

    int checks = 0;
    int errors = 0;
    int push_to = 0;

    // Result log: a handshake is recorded at the negedge before its edge.
    logic [24:0] res_log [2][256];
    int wr [2] = '{0, 0};
    int rd [2] = '{0, 0};

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n && res_valid[g] && res_ready[g]) begin
                res_log[g][wr[g] % 256] <= {res_ovf[g], res_count[g], res_sum[g]};
                wr[g] <= wr[g] + 1;
            end
        end
    end

    logic watch_en = 1'b0;
    logic en_drop  = 1'b0;
    always @(negedge clock) begin
        if (!watch_en) en_drop <= 1'b0;
        else if (!mult_en[0]) en_drop <= 1'b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one pair after 'gap' idle cycles; returns just after the accepting edge.
    task automatic push(input int g, input logic [3:0] a, input logic [3:0] b,
                        input logic last, input int gap);
        logic ok;
        in_valid[g] = 1'b0;
        repeat (gap) step();
        in_valid[g] = 1'b1;
        in_a[g] = a;
        in_b[g] = b;
        in_last[g] = last;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready[g];
            step();
        end
        in_valid[g] = 1'b0;
        in_a[g] = '0;
        in_b[g] = '0;
        in_last[g] = 1'b0;
        if (!ok) push_to++;
    endtask

    task automatic pop_result(input int g, output logic [15:0] s, output logic [7:0] c,
                              output logic o, output logic got);
        int n;
        n = 0;
        while (wr[g] <= rd[g] && n < 400) begin
            step();
            n++;
        end
        got = (wr[g] > rd[g]);
        {o, c, s} = got ? res_log[g][rd[g] % 256] : 25'd0;
        if (got) rd[g]++;
    endtask

    task automatic wait_valid(input int g, output int n);
        n = 0;
        while (!res_valid[g] && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({in_ready[g], res_valid[g], mult_en[g], res_ovf[g]} !== 4'b0000 ||
                res_sum[g] !== 16'd0 || res_count[g] !== 8'd0 || mult_x[g] !== 4'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b vld=%b en=%b sum=%0d cnt=%0d, req 0",
                         g, in_ready[g], res_valid[g], mult_en[g], res_sum[g], res_count[g]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (in_ready[g] !== 1'b1) begin
                errors++;
                $display("FAIL idle_ready dut%0d: in_ready=%b, req 1", g, in_ready[g]);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        res_ready[0] = 1'b0;
        push(0, 4'd3, 4'd5, 1'b0, 0);
        push(0, 4'd15, 4'd15, 1'b0, 0);
        push(0, 4'd2, 4'd7, 1'b1, 0);
        wait_valid(0, n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d, req 3", n);
        end
        checks++;
        if (res_sum[0] !== 16'd254 || res_count[0] !== 8'd3 || res_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%0d cnt=%0d ovf=%b, req 254/3/0",
                     res_sum[0], res_count[0], res_ovf[0]);
        end
        res_ready[0] = 1'b1;
        step();
        res_ready[0] = 1'b0;
        checks++;
        if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: vld=%b rdy=%b, req 0/1", res_valid[0], in_ready[0]);
        end
        checks++;
        if (push_to !== 0) begin
            errors++;
            $display("FAIL basic_push: timeouts=%0d, req 0", push_to);
        end
        push_to = 0;
        rd[0] = wr[0];
    endtask

    task automatic test_gaps();
        int n;
        res_ready[0] = 1'b0;
        push(0, 4'd3, 4'd5, 1'b0, 0);
        watch_en = 1'b1;
        push(0, 4'd15, 4'd15, 1'b0, 2);
        push(0, 4'd2, 4'd7, 1'b1, 2);
        wait_valid(0, n);
        checks++;
        if (en_drop !== 1'b0) begin
            errors++;
            $display("FAIL gaps_enable: dropped=%b, req 0", en_drop);
        end
        watch_en = 1'b0;
        checks++;
        if (res_valid[0] !== 1'b1 || res_sum[0] !== 16'd254 || res_count[0] !== 8'd3 ||
            res_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL gaps_result: vld=%b sum=%0d cnt=%0d ovf=%b, req 1/254/3/0",
                     res_valid[0], res_sum[0], res_count[0], res_ovf[0]);
        end
        res_ready[0] = 1'b1;
        step();
        res_ready[0] = 1'b0;
        rd[0] = wr[0];
        checks++;
        if (push_to !== 0) begin
            errors++;
            $display("FAIL gaps_push: timeouts=%0d, req 0", push_to);
        end
        push_to = 0;
    endtask

    task automatic test_wrap();
        logic [15:0] s;
        logic [7:0]  c;
        logic        o, got;
        res_ready[1] = 1'b1;
        push(1, 4'd15, 4'd15, 1'b0, 0);
        push(1, 4'd15, 4'd15, 1'b1, 0);
        push(1, 4'd1, 4'd1, 1'b1, 0);
        pop_result(1, s, c, o, got);
        checks++;
        if (!got || s !== 16'd194 || c !== 8'd2 || o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: got=%b sum=%0d cnt=%0d ovf=%b, req 1/194/2/1",
                     got, s, c, o);
        end
        pop_result(1, s, c, o, got);
        checks++;
        if (!got || s !== 16'd1 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_next: got=%b sum=%0d cnt=%0d ovf=%b, req 1/1/1/0",
                     got, s, c, o);
        end
    endtask

    task automatic test_max_len();
        logic [15:0] s;
        logic [7:0]  c;
        logic        o, got;
        res_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 4'd1, 4'd1, 1'b0, 0);
        checks++;
        if (in_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_hold: in_ready=%b, req 0", in_ready[1]);
        end
        push(1, 4'd1, 4'd1, 1'b0, 0);
        push(1, 4'd2, 4'd3, 1'b1, 0);
        pop_result(1, s, c, o, got);
        checks++;
        if (!got || s !== 16'd4 || c !== 8'd4 || o !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_first: got=%b sum=%0d cnt=%0d ovf=%b, req 1/4/4/0",
                     got, s, c, o);
        end
        pop_result(1, s, c, o, got);
        checks++;
        if (!got || s !== 16'd7 || c !== 8'd2 || o !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_carry: got=%b sum=%0d cnt=%0d ovf=%b, req 1/7/2/0",
                     got, s, c, o);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o, got;
        res_ready[0] = 1'b0;
        rd[0] = wr[0];
        push(0, 4'd4, 4'd5, 1'b1, 0);
        wait_valid(0, n);
        // Offered pairs must be ignored while the result is pending.
        in_valid[0] = 1'b1;
        in_a[0] = 4'd9;
        in_b[0] = 4'd9;
        in_last[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (res_valid[0] !== 1'b1 || res_sum[0] !== 16'd20 || res_count[0] !== 8'd1 ||
                res_ovf[0] !== 1'b0 || in_ready[0] !== 1'b0 || mult_x[0] !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: vld=%b sum=%0d cnt=%0d rdy=%b x=%0d, req 1/20/1/0/0",
                         i, res_valid[0], res_sum[0], res_count[0], in_ready[0], mult_x[0]);
            end
        end
        in_valid[0] = 1'b0;
        in_last[0] = 1'b0;
        res_ready[0] = 1'b1;
        step();
        res_ready[0] = 1'b0;
        checks++;
        if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b, req 0/1", res_valid[0], in_ready[0]);
        end
        checks++;
        if (wr[0] - rd[0] !== 1) begin
            errors++;
            $display("FAIL bp_count: handshakes=%0d, req 1", wr[0] - rd[0]);
        end
        pop_result(0, s, c, o, got);
        checks++;
        if (!got || s !== 16'd20 || c !== 8'd1) begin
            errors++;
            $display("FAIL bp_result: got=%b sum=%0d cnt=%0d, req 1/20/1", got, s, c);
        end
        rd[0] = wr[0];
    endtask

    task automatic test_reset_mid();
        int base;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o, got;
        res_ready[0] = 1'b1;
        push(0, 4'd7, 4'd7, 1'b0, 0);
        push(0, 4'd1, 4'd2, 1'b0, 0);
        rst_n = 1'b0;
        step();
        checks++;
        if ({in_ready[0], mult_en[0], res_valid[0], res_ovf[0]} !== 4'b0000 ||
            mult_x[0] !== 4'd0 || mult_y[0] !== 4'd0 || res_sum[0] !== 16'd0 ||
            res_count[0] !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state: rdy=%b en=%b vld=%b x=%0d y=%0d sum=%0d cnt=%0d, req 0",
                     in_ready[0], mult_en[0], res_valid[0], mult_x[0], mult_y[0],
                     res_sum[0], res_count[0]);
        end
        rst_n = 1'b1;
        base = wr[0];
        repeat (8) step();
        checks++;
        if (wr[0] !== base) begin
            errors++;
            $display("FAIL midreset_silent: results=%0d, req 0", wr[0] - base);
        end
        rd[0] = wr[0];
        push(0, 4'd2, 4'd3, 1'b1, 0);
        pop_result(0, s, c, o, got);
        checks++;
        if (!got || s !== 16'd6 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: got=%b sum=%0d cnt=%0d ovf=%b, req 1/6/1/0",
                     got, s, c, o);
        end
        checks++;
        if (push_to !== 0) begin
            errors++;
            $display("FAIL midreset_push: timeouts=%0d, req 0", push_to);
        end
        push_to = 0;
    endtask

    task automatic test_random(input int g, input int nvec);
        int aw, ml, tsum, tcnt, len;
        logic [3:0]  a, b;
        logic [24:0] exp_q [$];
        logic [15:0] s;
        logic [7:0]  c;
        logic        o, got, done;
        aw = (g == 0) ? 16 : 8;
        ml = (g == 0) ? 255 : 4;
        tsum = 0;
        tcnt = 0;
        done = 1'b0;
        rd[g] = wr[g];
        fork
            begin
                for (int v = 0; v < nvec; v++) begin
                    len = $urandom_range(1, 7);
                    for (int k = 0; k < len; k++) begin
                        a = 4'($urandom_range(0, 15));
                        b = 4'($urandom_range(0, 15));
                        push(g, a, b, k == len - 1, $urandom_range(0, 2));
                        tsum += int'(a) * int'(b);
                        tcnt++;
                        if (k == len - 1 || tcnt == ml) begin
                            exp_q.push_back({tsum >= (1 << aw), 8'(tcnt),
                                             16'(tsum % (1 << aw))});
                            tsum = 0;
                            tcnt = 0;
                        end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step();
                    res_ready[g] = ($urandom_range(0, 1) == 1);
                end
            end
        join
        res_ready[g] = 1'b1;
        foreach (exp_q[i]) begin
            pop_result(g, s, c, o, got);
            checks++;
            if (!got || {o, c, s} !== exp_q[i]) begin
                errors++;
                $display("FAIL random dut%0d vec%0d: got=%b sum=%0d cnt=%0d ovf=%b, req %0d/%0d/%b",
                         g, i, got, s, c, o, exp_q[i][15:0], exp_q[i][23:16], exp_q[i][24]);
            end
        end
        checks++;
        if (push_to !== 0) begin
            errors++;
            $display("FAIL random_push dut%0d: timeouts=%0d, req 0", g, push_to);
        end
        push_to = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0;
            in_last[g] = 1'b0;
            in_a[g] = '0;
            in_b[g] = '0;
            res_ready[g] = 1'b0;
        end
        step();
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_max_len();
        test_backpressure();
        test_reset_mid();
        test_random(0, 12);
        test_random(1, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
